tiny_alu_core: RTL
==================

// Module: tiny_alu_core
// PURPOSE
//  Operand-level ALU that sits directly downstream of the ALU bus-functional interface.
//  Captures A/B/op on a start/done handshake and returns a 16-bit result.
//  add/and/xor complete in one cycle; mul uses an iterative shift-add unit.
//  Serves as the DUT target for the tb0 driver/monitor environment.
// PARAMETERS
//  WIDTH     8          operand width; result width is 2*WIDTH
//  MUL_ITER  WIDTH      shift-add iterations for mul (one operand bit per cycle)
// PORTS
//  clk      in   1        single clock; all state changes on posedge
//  reset    in   1        asynchronous, active-high reset
//  A        in   WIDTH    operand A, unsigned bit pattern
//  B        in   WIDTH    operand B, unsigned bit pattern
//  op       in   3        opcode: 0 no_op, 1 add, 2 and, 3 xor, 4 mul, 7 rst_op; 5/6 unused
//  start    in   1        request; held high by the master until done is seen
//  done     out  1        one-cycle completion pulse
//  result   out  2*WIDTH  operation result; holds its value until the next completion
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, done=0, result=0, multiplier cleared.
//  FSM states IDLE, CALC, MUL_RUN, WAIT_REL.
//   IDLE: on posedge with start=1, sample op/A/B.
//    op 1/2/3 -> CALC.  op 4 -> MUL_RUN.  op 0/5/6/7 -> remain in IDLE; no done, result unchanged.
//   CALC: result <= op result; done=1 for this cycle; next state WAIT_REL.
//    Latency is 1 cycle (accept edge N, done high N+1).
//   MUL_RUN: MUL_ITER shift-add steps.
//    After the last step: result <= product, done=1 for one cycle, then WAIT_REL.
//    Latency is MUL_ITER+1 cycles from accept (9 for WIDTH=8).
//   WAIT_REL: done=0; stay until start is sampled 0, then go to IDLE.
//    Prevents a still-high start from retriggering the same operation.
//  Arithmetic:
//   add: zero-extended, {0,A}+{0,B}; carry lands in bit WIDTH.
//   and/xor: zero-extended to 2*WIDTH.
//   mul: unsigned WIDTH x WIDTH -> 2*WIDTH; no truncation.
//  Operand capture: operands and op are latched at accept.
//   Input changes while in CALC, MUL_RUN or WAIT_REL are ignored.
//  done is asserted only from CALC or at MUL_RUN completion, never two consecutive cycles.
//  Reset mid-operation: aborts immediately; no done pulse; result=0.
//  start high on the first posedge after reset release is accepted normally.
//  start=1 with reset=1: ignored.
//  result is registered; it changes only on a done cycle or on reset.
// STRUCTURE
//  Shared package alu_pkg holds:
//   operation_t enum (no_op=0, add_op=1, and_op=2, xor_op=3, mul_op=4, rst_op=7)
//   state_t enum for the FSM
//   WIDTH default constant
//  tb_pkg imports alu_pkg so the driver and the DUT share one opcode definition.
//  Sub-module alu_mul_seq (clk, reset, go, a, b, busy, last, product).
//   Holds the shift-add datapath and the iteration counter.
//   tiny_alu_core keeps the FSM, handshake and single-cycle ops.
// TESTING
//  1 add A=8'hFF B=8'h01 -> done at accept+1, result=16'h0100; start dropped -> IDLE.
//  2 and F0&3C -> 16'h0030.  xor AA^55 -> 16'h00FF.  Each done a single-cycle pulse.
//  3 mul FF*FF -> done exactly 9 cycles after accept, result=16'hFE01.
//    A/B toggled during MUL_RUN have no effect on result.
//  4 no_op with start held 1 cycle -> done never rises, prior result holds.
//    Repeat for op=5, op=6 and op=7.
//  5 reset during mul step 4 -> done stays 0, result=0.
//    Next add 2+3 -> result=16'h0005 at accept+1.
//  6 start held high 5 cycles past done -> exactly one done pulse.
//    Back-to-back add then mul with one low cycle between -> two correct completions.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the tiny ALU: opcode encoding, FSM states and
// the default operand width. The driver side imports the same package so
// both ends agree on one opcode table.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4,
    rst_op = 3'd7
  } operation_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC     = 2'd1,
    MUL_RUN  = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle.
// 'go' loads the operands, 'busy' is high while steps remain, and 'last'
// pulses for one cycle once the final partial product has been added, at
// which point 'product' holds the full unsigned 2*WIDTH result.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(ITER + 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               run_q;
  logic               last_q;

  logic [2*WIDTH-1:0] accSum_d;
  logic               finalStep;

  // Next accumulator value adds the shifted multiplicand when the current
  // multiplier LSB is set; finalStep marks the cycle doing the last step.
  always_comb begin
    accSum_d  = acc_q;
    if (mplier_q[0]) begin
      accSum_d = acc_q + mcand_q;
    end
    finalStep = run_q && (cnt_q == CNT_W'(ITER - 1));
  end

  // Datapath and iteration counter; a new load is only taken while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      last_q <= 1'b0;
      if (go && !run_q) begin
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
        cnt_q    <= '0;
        run_q    <= 1'b1;
      end else if (run_q) begin
        acc_q    <= accSum_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        run_q    <= !finalStep;
        last_q   <= finalStep;
      end
    end
  end

  assign busy    = run_q;
  assign last    = last_q;
  assign product = acc_q;

endmodule

// File: rtl/tiny_alu_core.sv
// Operand-level ALU behind a start/done handshake. add/and/xor finish one
// cycle after accept; mul runs through alu_mul_seq and finishes
// MUL_ITER+1 cycles after accept. WAIT_REL stops a still-high start from
// re-running the same operation.
module tiny_alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MUL_ITER = WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  state_t             state_q;
  operation_t         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               done_q;
  logic [2*WIDTH-1:0] result_q;

  logic [2*WIDTH-1:0] calcResult;
  logic               mulGo;
  logic               mulBusy;
  logic               mulLast;
  logic [2*WIDTH-1:0] mulProduct;

  // The multiplier loads straight from the ports on the accept edge so
  // its first step lands on the following cycle.
  assign mulGo = (state_q == IDLE) && start && (op == mul_op) && !mulBusy;

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .ITER  (MUL_ITER)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .go      (mulGo),
    .a       (A),
    .b       (B),
    .busy    (mulBusy),
    .last    (mulLast),
    .product (mulProduct)
  );

  // Single-cycle operations on the latched operands, all zero-extended.
  always_comb begin
    calcResult = '0;
    case (op_q)
      add_op:  calcResult = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
      and_op:  calcResult = {{WIDTH{1'b0}}, a_q & b_q};
      xor_op:  calcResult = {{WIDTH{1'b0}}, a_q ^ b_q};
      default: calcResult = '0;
    endcase
  end

  // Handshake FSM with registered done and result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= no_op;
      a_q      <= '0;
      b_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q <= operation_t'(op);
            a_q  <= A;
            b_q  <= B;
            case (op)
              add_op, and_op, xor_op: state_q <= CALC;
              mul_op:                 state_q <= MUL_RUN;
              default:                state_q <= IDLE;
            endcase
          end
        end
        CALC: begin
          result_q <= calcResult;
          done_q   <= 1'b1;
          state_q  <= WAIT_REL;
        end
        MUL_RUN: begin
          if (mulLast) begin
            result_q <= mulProduct;
            done_q   <= 1'b1;
            state_q  <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!start) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
